// File: rtl/sqrt_stream_core_pkg.sv
// rtl/sqrt_stream_core_pkg.sv - root_pkg: FSM encoding and width helpers for the streaming square-root core
package root_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PUSH = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        int v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int half_w(input int width);
        return width / 2;
    endfunction

    // Remainder needs two guard bits above the root width while shifting in digit pairs.
    function automatic int rem_w(input int width);
        return width / 2 + 2;
    endfunction

endpackage

// File: rtl/sqrt_stream_core_if.sv
// rtl/sqrt_stream_core_if.sv - operand/result stream interface; SQRT_REM_EN adds out_rem
interface sqrt_stream_core_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH/2-1:0] out_root;
    logic               out_valid;
    logic               out_ready;
`ifdef SQRT_REM_EN
    logic [WIDTH/2:0]   out_rem;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_root, out_valid, out_rem);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_root, out_valid, out_rem);
`else
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_root, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_root, out_valid);
`endif

endinterface

// File: rtl/sqrt_stream_core_fifo.sv
// rtl/sqrt_stream_core_fifo.sv - root_result_fifo: synchronous first-word fall-through result FIFO
module root_result_fifo
    import root_pkg::*;
#(
    parameter int ENTRY_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [ENTRY_W-1:0]      wr_data,
    input  logic                    pop,
    output logic [ENTRY_W-1:0]      rd_data,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sqrt_stream_core.sv
// rtl/sqrt_stream_core.sv - iterative digit-by-digit integer square root with result FIFO
// Optional SQRT_REM_EN stores the remainder with each root and exposes it as out_rem.
module sqrt_stream_core
    import root_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sqrt_stream_core_if.slave     s,
    output logic                  busy,
    output logic [clog2(DEPTH):0] fifo_count
);

    localparam int HALF  = half_w(WIDTH);
    localparam int REM_W = rem_w(WIDTH);
    localparam int IT_W  = clog2(HALF) + 1;
`ifdef SQRT_REM_EN
    localparam int ENTRY_W = HALF + HALF + 1;
`else
    localparam int ENTRY_W = HALF;
`endif

    state_t             state;
    state_t             state_d;
    logic [WIDTH-1:0]   x_sh;
    logic [HALF-1:0]    root;
    logic [REM_W-1:0]   rem;
    logic [IT_W-1:0]    iter;
    logic [REM_W-1:0]   rem_t;
    logic [REM_W-1:0]   trial;
    logic               ge;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    always_comb begin
        rem_t   = {rem[REM_W-3:0], x_sh[WIDTH-1 -: 2]};
        trial   = {root, 2'b01};
        ge      = (rem_t >= trial);
        push    = 1'b0;
        state_d = state;
        case (state)
            IDLE: if (s.in_valid) state_d = CALC;
            CALC: if (iter == IT_W'(HALF - 1)) state_d = PUSH;
            PUSH: begin
                push = !fifo_full;
                if (!fifo_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sh <= '0;
            root <= '0;
            rem  <= '0;
            iter <= '0;
        end else begin
            case (state)
                IDLE: if (s.in_valid) begin
                    x_sh <= s.in_data;
                    root <= '0;
                    rem  <= '0;
                    iter <= '0;
                end
                CALC: begin
                    x_sh <= x_sh << 2;
                    iter <= iter + IT_W'(1);
                    if (ge) begin
                        rem  <= rem_t - trial;
                        root <= {root[HALF-2:0], 1'b1};
                    end else begin
                        rem  <= rem_t;
                        root <= {root[HALF-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign s.in_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign s.out_valid = !fifo_empty;

    // The final remainder never exceeds 2*root, so only HALF+1 bits carry information.
`ifdef SQRT_REM_EN
    logic unused_rem_msb;
    assign unused_rem_msb = rem[REM_W-1];
    assign wr_data        = {root, rem[HALF:0]};
    assign s.out_root     = rd_data[ENTRY_W-1 -: HALF];
    assign s.out_rem      = rd_data[HALF:0];
`else
    logic [1:0] unused_rem_msb;
    assign unused_rem_msb = rem[REM_W-1:REM_W-2];
    assign wr_data        = root;
    assign s.out_root     = rd_data;
`endif

    root_result_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_data),
        .pop     (s.out_ready),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
